// File: rtl/bit_serial_mac_if.sv
// Handshake bundle between the input vector buffer, the bit-serial MAC and the
// result consumer. The MAC connects through the slave modport.
interface bit_serial_mac_if #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 128,
    parameter int W_W    = 8
);
    localparam int ACC_W = DATA_W + W_W + $clog2(N_IN);

    logic [N_IN*DATA_W-1:0] invec_bus;
    logic                   vector_done;
    logic [N_IN*W_W-1:0]    w_bus;
    logic                   busy;
    logic [ACC_W-1:0]       acc_out;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overrun;

    modport master (
        output invec_bus, vector_done, w_bus, out_ready,
        input  busy, acc_out, out_valid, overrun
    );

    modport slave (
        input  invec_bus, vector_done, w_bus, out_ready,
        output busy, acc_out, out_valid, overrun
    );
endinterface

// File: rtl/bit_serial_mac.sv
// Bit-serial signed dot product: one input bit-plane per cycle, MSB first, Horner accumulate.
// Optional macro BIT_SERIAL_MAC_RELU_EN clamps negative results to zero.
module bit_serial_mac #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 128,
    parameter int W_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bit_serial_mac_if.slave  bus
);
    localparam int ACC_W  = DATA_W + W_W + $clog2(N_IN);
    localparam int PART_W = W_W + $clog2(N_IN);
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state;
    logic [N_IN*DATA_W-1:0]    x_reg;
    logic [N_IN*W_W-1:0]       w_reg;
    logic [CNT_W-1:0]          bit_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   partial_ext;
    logic signed [ACC_W-1:0]   result;
    logic signed [PART_W-1:0]  partial;
    logic                      first_plane;

    // Sum of the weights whose input has a 1 in the current bit-plane.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        partial = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (x_reg[i*DATA_W + int'(bit_cnt)])
                partial = partial + PART_W'(signed'(w_reg[i*W_W +: W_W]));
        end
    end

    // The MSB plane carries negative weight in two's complement.
    assign first_plane = (bit_cnt == CNT_W'(DATA_W - 1));
    assign partial_ext = ACC_W'(partial);
    assign acc_next    = first_plane ? -partial_ext : (acc <<< 1) + partial_ext;

`ifdef BIT_SERIAL_MAC_RELU_EN
    assign result = acc[ACC_W-1] ? '0 : acc;
`else
    assign result = acc;
`endif

    assign bus.busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            x_reg         <= '0;
            w_reg         <= '0;
            bit_cnt       <= '0;
            acc           <= '0;
            bus.acc_out   <= '0;
            bus.out_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            if (bus.vector_done && state != IDLE)
                bus.overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (bus.vector_done) begin
                        x_reg   <= bus.invec_bus;
                        w_reg   <= bus.w_bus;
                        acc     <= '0;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == '0)
                        state <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the finished accumulator.
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end else if (!bus.out_valid) begin
                        bus.acc_out   <= result;
                        bus.out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_mac.sv
// Self-checking bench for bit_serial_mac (DATA_W=8, N_IN=4, W_W=4): vector table,
// hand-written corner sequences and randomized vectors against a dot-product model.
module tb_bit_serial_mac;
    localparam int DATA_W = 8;
    localparam int N_IN   = 4;
    localparam int W_W    = 4;

    typedef int vec_t [N_IN];

    typedef struct {
        string name;
        vec_t  x;
        vec_t  w;
        int    raw;
    } vec_rec_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    bit_serial_mac_if #(.DATA_W(DATA_W), .N_IN(N_IN), .W_W(W_W)) bus ();

    bit_serial_mac #(.DATA_W(DATA_W), .N_IN(N_IN), .W_W(W_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint relu(input longint v);
`ifdef BIT_SERIAL_MAC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic longint ref_dot(input vec_t x, input vec_t w);
        longint s = 0;
        for (int i = 0; i < N_IN; i++) s += longint'(x[i]) * longint'(w[i]);
        return relu(s);
    endfunction

    function automatic logic [N_IN*DATA_W-1:0] pack_x(input vec_t v);
        logic [N_IN*DATA_W-1:0] r = '0;
        for (int i = 0; i < N_IN; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
        return r;
    endfunction

    function automatic logic [N_IN*W_W-1:0] pack_w(input vec_t v);
        logic [N_IN*W_W-1:0] r = '0;
        for (int i = 0; i < N_IN; i++) r[i*W_W +: W_W] = W_W'(v[i]);
        return r;
    endfunction

    function automatic longint acc_val();
        return longint'($signed(bus.acc_out));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input vec_t x, input vec_t w);
        bus.invec_bus   = pack_x(x);
        bus.w_bus       = pack_w(w);
        bus.vector_done = 1'b1;
        tick();
        bus.vector_done = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic scramble_inputs();
        bus.invec_bus = {$urandom, $urandom};
        bus.w_bus     = N_IN*W_W'($urandom);
    endtask

    function automatic vec_t rand_x();
        vec_t v;
        for (int i = 0; i < N_IN; i++) v[i] = int'($urandom_range(0, 255)) - 128;
        return v;
    endfunction

    function automatic vec_t rand_w();
        vec_t v;
        for (int i = 0; i < N_IN; i++) v[i] = int'($urandom_range(0, 15)) - 8;
        return v;
    endfunction

    initial begin
        vec_rec_t tbl [6];
        vec_t     xa, wa, xb, wb;
        int       lat;
        longint   held;

        // Raw dot products worked out by hand; the optional clamp is applied at compare time.
        tbl[0] = '{"basic",      '{1, 2, 3, 4},         '{1, 1, 1, 1},     10};
        tbl[1] = '{"neg_neg",    '{-128, -128, -128, -128}, '{-8, -8, -8, -8}, 4096};
        tbl[2] = '{"neg_pos",    '{-128, -128, -128, -128}, '{7, 7, 7, 7},  -3584};
        tbl[3] = '{"pos_max",    '{127, 127, 127, 127}, '{7, 7, 7, 7},     3556};
        tbl[4] = '{"mixed",      '{127, -128, 0, -1},   '{-8, 7, 3, -8},  -1904};
        tbl[5] = '{"zero_x",     '{0, 0, 0, 0},         '{5, -3, 2, 1},    0};

        rst_n           = 1'b0;
        bus.invec_bus   = '0;
        bus.w_bus       = '0;
        bus.vector_done = 1'b0;
        bus.out_ready   = 1'b0;
        tick();
        tick();
        check("reset_busy", bus.busy, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_acc_out", acc_val(), 0);
        check("reset_overrun", bus.overrun, 0);
        rst_n = 1'b1;
        tick();

        // Basic timing: busy next cycle, result 9 edges after sampling, busy drops after handshake.
        start(tbl[0].x, tbl[0].w);
        check("basic_busy_after_done", bus.busy, 1);
        check("basic_valid_low_in_run", bus.out_valid, 0);
        wait_valid(lat);
        check("basic_latency", lat, DATA_W + 1);
        check("basic_acc", acc_val(), relu(tbl[0].raw));
        accept();
        check("basic_valid_cleared", bus.out_valid, 0);
        check("basic_busy_cleared", bus.busy, 0);

        foreach (tbl[k]) begin
            start(tbl[k].x, tbl[k].w);
            scramble_inputs();
            wait_valid(lat);
            check({tbl[k].name, "_latency"}, lat, DATA_W + 1);
            check({tbl[k].name, "_acc"}, acc_val(), relu(tbl[k].raw));
            accept();
            check({tbl[k].name, "_idle"}, bus.busy, 0);
        end

        // Backpressure: result and status stay put while the consumer stalls.
        xa = '{-5, 100, -77, 12};
        wa = '{3, -8, 6, -1};
        start(xa, wa);
        wait_valid(lat);
        held = acc_val();
        check("bp_acc", held, ref_dot(xa, wa));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_acc_stable", acc_val(), held);
            check("bp_valid_held", bus.out_valid, 1);
            check("bp_busy_held", bus.busy, 1);
        end
        accept();
        check("bp_valid_cleared", bus.out_valid, 0);
        check("bp_busy_cleared", bus.busy, 0);
        tick();
        check("bp_single_handshake", bus.out_valid, 0);
        check("bp_acc_kept", acc_val(), held);

        // Overrun: a second vector_done during RUN is ignored but flagged, and the flag sticks.
        xa = '{50, -60, 70, -80};
        wa = '{-7, 5, 2, -3};
        xb = '{1, 1, 1, 1};
        wb = '{1, 1, 1, 1};
        check("ovr_clear_before", bus.overrun, 0);
        start(xa, wa);
        tick();
        tick();
        start(xb, wb);
        check("ovr_flag_set", bus.overrun, 1);
        wait_valid(lat);
        check("ovr_latency_from_first", lat, DATA_W + 1 - 3);
        check("ovr_acc_first_snapshot", acc_val(), ref_dot(xa, wa));
        accept();
        check("ovr_idle", bus.busy, 0);
        tick();
        check("ovr_sticky_in_idle", bus.overrun, 1);

        // Snapshot isolation: bus contents change right after the sampling edge.
        xa = '{-100, 33, 90, -1};
        wa = '{4, -4, 7, -8};
        start(xa, wa);
        bus.invec_bus = pack_x('{127, 127, 127, 127});
        bus.w_bus     = pack_w('{7, 7, 7, 7});
        wait_valid(lat);
        check("snap_acc", acc_val(), ref_dot(xa, wa));
        accept();

        // Reset while bit_cnt is 4 (fourth RUN cycle) aborts everything.
        xa = '{9, -9, 19, -19};
        wa = '{-2, 3, 1, 6};
        check("rst_prior_acc_nonzero", (acc_val() != 0) ? 1 : 0, 1);
        start(xa, wa);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_acc_out", acc_val(), 0);
        check("rst_overrun", bus.overrun, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("rst_no_late_result", bus.out_valid, 0);
        end
        start(xa, wa);
        wait_valid(lat);
        check("rst_new_latency", lat, DATA_W + 1);
        check("rst_new_acc", acc_val(), ref_dot(xa, wa));

        // vector_done together with the DONE handshake is dropped and flagged.
        bus.invec_bus   = pack_x('{3, 3, 3, 3});
        bus.w_bus       = pack_w('{2, 2, 2, 2});
        bus.vector_done = 1'b1;
        bus.out_ready   = 1'b1;
        tick();
        bus.vector_done = 1'b0;
        bus.out_ready   = 1'b0;
        check("hs_done_busy", bus.busy, 0);
        check("hs_done_valid", bus.out_valid, 0);
        check("hs_done_overrun", bus.overrun, 1);
        tick();
        tick();
        check("hs_done_no_run", bus.busy, 0);

        // Randomized vectors with random consumer stalls.
        for (int n = 0; n < 40; n++) begin
            int stall;
            xa = rand_x();
            wa = rand_w();
            stall = int'($urandom_range(0, 3));
            start(xa, wa);
            scramble_inputs();
            wait_valid(lat);
            check("rand_latency", lat, DATA_W + 1);
            for (int s = 0; s < stall; s++) tick();
            check("rand_acc", acc_val(), ref_dot(xa, wa));
            accept();
            check("rand_idle", bus.busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
